pwc_tile_feeder: RTL and testbench

Input stage of the pointwise-convolution path, sitting directly upstream of the 32-channel 1x1 PE. It captures one 8x4 spatial tile of P_CH-channel pixels into a ping-pong buffer, then replays every pixel of the tile once per output-channel group. Each replay beat is issued as a Feature_Input / Feature_Input_Valid beat, tagged with the weight group the PE must apply. Capture of the next tile overlaps replay of the current one.

---
 rtl/pwc_tile_feeder.sv | 166 ++++++++++++++++
 tb/tb_pwc_tile_feeder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwc_tile_feeder.sv
// Ping-pong tile buffer feeding the 1x1 PE: captures one tile of pixels and
// replays it once per output-channel weight group while the next tile fills.
`timescale 1ns/1ps

module pwc_tile_feeder #(
    parameter int DWIDTH    = 8,
    parameter int P_CH      = 32,
    parameter int TILE_PIX  = 32,
    parameter int OC_GROUPS = 8,
    localparam int PIX_W    = DWIDTH * P_CH,
    localparam int GW       = (OC_GROUPS > 1) ? $clog2(OC_GROUPS) : 1,
    localparam int PW       = (TILE_PIX > 1) ? $clog2(TILE_PIX) : 1,
    localparam int AW       = $clog2(2 * TILE_PIX)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] s_pixel,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             pe_ready,
    output logic [PIX_W-1:0] Feature_Input,
    output logic             Feature_Input_Valid,
    output logic [GW-1:0]    weight_grp,
    output logic             group_first,
    output logic             group_last,
    output logic             tile_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]    full_reg, full_next;
    logic          wbank_reg, rbank_reg;
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] p_reg;
    logic [GW-1:0] g_reg;

    logic [PIX_W-1:0] mem [0:2*TILE_PIX-1];
    logic [AW-1:0]    wr_addr, rd_addr;

    logic wr_en, wr_last;
    logic p_last, g_last;
    logic issue, rd_last;

    // ---------------- write side ----------------
    assign s_ready = ~full_reg[wbank_reg];
    assign wr_en   = s_valid & s_ready;
    assign wr_last = wr_en && (wptr_reg == PW'(TILE_PIX - 1));
    assign wr_addr = wbank_reg ? (AW'(TILE_PIX) + AW'(wptr_reg)) : AW'(wptr_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg  <= '0;
            wbank_reg <= 1'b0;
        end else if (wr_en) begin
            if (wr_last) begin
                wptr_reg  <= '0;
                wbank_reg <= ~wbank_reg;
            end else begin
                wptr_reg <= wptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= s_pixel;
    end

    // Fill and release in the same edge always touch different banks.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign full_next[gi] = (wr_last && (wbank_reg == 1'(gi))) ? 1'b1 :
                                   (rd_last && (rbank_reg == 1'(gi))) ? 1'b0 :
                                   full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            full_reg <= '0;
        else
            full_reg <= full_next;
    end

    // ---------------- read FSM ----------------
    assign p_last  = (p_reg == PW'(TILE_PIX - 1));
    assign g_last  = (g_reg == GW'(OC_GROUPS - 1));
    assign rd_addr = rbank_reg ? (AW'(TILE_PIX) + AW'(p_reg)) : AW'(p_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (full_reg[rbank_reg])
                    state_next = ISSUE;
            end
            ISSUE: begin
                // Chain straight into the other bank when it is already waiting.
                if (rd_last && !full_reg[~rbank_reg])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue   = 1'b0;
        rd_last = 1'b0;
        if ((state_reg == ISSUE) && pe_ready) begin
            issue   = 1'b1;
            rd_last = p_last && g_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_reg     <= '0;
            g_reg     <= '0;
            rbank_reg <= 1'b0;
        end else if (issue) begin
            if (p_last) begin
                p_reg <= '0;
                g_reg <= g_last ? '0 : (g_reg + GW'(1));
            end else begin
                p_reg <= p_reg + PW'(1);
            end
            if (rd_last)
                rbank_reg <= ~rbank_reg;
        end
    end

    // ---------------- output register (doubles as the RAM read register) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Feature_Input       <= '0;
            Feature_Input_Valid <= 1'b0;
            weight_grp          <= '0;
            group_first         <= 1'b0;
            group_last          <= 1'b0;
            tile_done           <= 1'b0;
        end else begin
            Feature_Input_Valid <= issue;
            group_first         <= issue && (p_reg == '0);
            group_last          <= issue && p_last;
            tile_done           <= rd_last;
            if (issue) begin
                Feature_Input <= mem[rd_addr];
                weight_grp    <= g_reg;
            end
        end
    end

endmodule

// File: tb/tb_pwc_tile_feeder.sv
// Self-checking bench for pwc_tile_feeder: reset vector table, then scoreboarded
// tile replays covering latency, ping-pong backpressure, PE stalls, idle gaps and reset.
`timescale 1ns/1ps

module tb_pwc_tile_feeder;

    localparam int DWIDTH    = 8;
    localparam int P_CH      = 32;
    localparam int TILE_PIX  = 32;
    localparam int OC_GROUPS = 8;
    localparam int PIX_W     = DWIDTH * P_CH;
    localparam int GW        = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [PIX_W-1:0] s_pixel = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             pe_ready = 1'b1;
    logic [PIX_W-1:0] Feature_Input;
    logic             Feature_Input_Valid;
    logic [GW-1:0]    weight_grp;
    logic             group_first, group_last, tile_done;

    always #5 clk = ~clk;

    pwc_tile_feeder #(
        .DWIDTH(DWIDTH), .P_CH(P_CH), .TILE_PIX(TILE_PIX), .OC_GROUPS(OC_GROUPS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .pe_ready(pe_ready),
        .Feature_Input(Feature_Input), .Feature_Input_Valid(Feature_Input_Valid),
        .weight_grp(weight_grp), .group_first(group_first),
        .group_last(group_last), .tile_done(tile_done)
    );

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [GW-1:0]    grp;
        logic             first;
        logic             last;
        logic             done;
    } beat_t;

    typedef struct {
        logic       rst_n;
        logic       sv;
        logic       pr;
        logic [7:0] byt;
        logic       exp_ready;
        logic       exp_valid;
    } vec_t;

    beat_t            exp_q[$];
    beat_t            got_b, exp_b;
    logic [PIX_W-1:0] tile_buf [TILE_PIX];
    int               checks = 0;
    int               errors = 0;
    int               beat_cnt = 0;
    int               idle_cnt = 0;
    int               accepted = 0;
    int               acc_at_stall = -1;
    bit               count_idle = 1'b0;
    bit               arm_first = 1'b0;
    time              t_first = 0;
    time              t_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected replay: every pixel of the tile, group by group.
    function automatic void push_tile();
        beat_t b;
        for (int g = 0; g < OC_GROUPS; g++) begin
            for (int p = 0; p < TILE_PIX; p++) begin
                b.data  = tile_buf[p];
                b.grp   = GW'(g);
                b.first = (p == 0);
                b.last  = (p == TILE_PIX - 1);
                b.done  = (p == TILE_PIX - 1) && (g == OC_GROUPS - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (Feature_Input_Valid) begin
                got_b.data  = Feature_Input;
                got_b.grp   = weight_grp;
                got_b.first = group_first;
                got_b.last  = group_last;
                got_b.done  = tile_done;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat %0d unexpected: grp=%0d fld=%b%b%b word0=%h",
                             beat_cnt, weight_grp, group_first, group_last, tile_done,
                             Feature_Input[31:0]);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        errors++;
                        $display("FAIL beat %0d: got grp=%0d fld=%b%b%b word0=%h expected grp=%0d fld=%b%b%b word0=%h",
                                 beat_cnt, got_b.grp, got_b.first, got_b.last, got_b.done,
                                 got_b.data[31:0], exp_b.grp, exp_b.first, exp_b.last,
                                 exp_b.done, exp_b.data[31:0]);
                    end
                end
                if (arm_first) begin
                    t_first   = $time;
                    arm_first = 1'b0;
                end
                beat_cnt++;
            end else if (count_idle && exp_q.size() > 0) begin
                idle_cnt++;
            end
        end
    end

    // All driver tasks start and end at 1 ns after a rising edge.
    task automatic send_pix(input logic [PIX_W-1:0] d);
        int n;
        bit waited;
        n = 0;
        waited = 1'b0;
        while (!s_ready && n < 2000) begin
            if (acc_at_stall < 0)
                acc_at_stall = accepted;
            waited = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", 64'(s_ready), 64'd1);
            return;
        end
        if (waited)
            chk("reopen_at_tile_done", 64'(tile_done), 64'd1);
        s_pixel = d;
        s_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        accepted++;
        #1;
        s_valid = 1'b0;
    endtask

    // kind 0: every byte of pixel k equals k; kind 1: random pixel words.
    task automatic send_tile(input int gap, input int kind, input int hold_last);
        for (int k = 0; k < TILE_PIX; k++) begin
            if (kind == 0) begin
                for (int j = 0; j < P_CH; j++)
                    tile_buf[k][j*DWIDTH +: DWIDTH] = DWIDTH'(k);
            end else begin
                for (int j = 0; j < PIX_W / 32; j++)
                    tile_buf[k][j*32 +: 32] = $urandom;
            end
        end
        for (int k = 0; k < TILE_PIX; k++) begin
            if (k == TILE_PIX - 1 && hold_last > 0) begin
                repeat (hold_last) begin @(posedge clk); #1; end
                chk("no_beat_partial_tile", 64'(Feature_Input_Valid), 64'd0);
            end
            send_pix(tile_buf[k]);
            if (k < TILE_PIX - 1)
                repeat (gap) begin @(posedge clk); #1; end
        end
        push_tile();
    endtask

    task automatic check_latency();
        int n;
        n = 0;
        while (arm_first && n < 50) begin @(posedge clk); #1; n++; end
        chk("first_beat_latency_ns", 64'(t_first - t_acc), 64'd25);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin @(posedge clk); #1; n++; end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 2000) begin @(posedge clk); #1; n++; end
        chk("wait_beats_reached", 64'(beat_cnt >= target), 64'd1);
    endtask

    task automatic stall(input int len);
        pe_ready = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            chk("stall_valid_low", 64'(Feature_Input_Valid), 64'd0);
        end
        pe_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_resume_valid", 64'(Feature_Input_Valid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   b0;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};

        // Reset and post-release quiescence
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            reset_n  = vecs[i].rst_n;
            s_valid  = vecs[i].sv;
            pe_ready = vecs[i].pr;
            s_pixel  = {P_CH{vecs[i].byt}};
            @(negedge clk);
            chk("vec_s_ready", 64'(s_ready), 64'(vecs[i].exp_ready));
            chk("vec_valid", 64'(Feature_Input_Valid), 64'(vecs[i].exp_valid));
            chk("vec_feature_input", Feature_Input[63:0], 64'd0);
            chk("vec_flags", 64'({weight_grp, group_first, group_last, tile_done}), 64'd0);
        end
        s_valid  = 1'b0;
        pe_ready = 1'b1;
        @(posedge clk); #1;

        // Single tile with byte pattern k, pause before the final pixel
        arm_first = 1'b1;
        send_tile(0, 0, 10);
        check_latency();
        drain();

        // Three tiles streamed back to back
        acc_at_stall = -1;
        accepted     = 0;
        idle_cnt     = 0;
        b0           = beat_cnt;
        fork
            begin
                for (int t = 0; t < 3; t++)
                    send_tile(0, 1, 0);
            end
            begin
                int n;
                n = 0;
                while (beat_cnt == b0 && n < 200) begin @(posedge clk); #1; n++; end
                count_idle = 1'b1;
            end
        join
        drain();
        count_idle = 1'b0;
        chk("accepted_before_backpressure", 64'(acc_at_stall), 64'd64);
        chk("idle_cycles_between_tiles", 64'(idle_cnt), 64'd0);

        // PE stalls: mid-group and across a group boundary
        b0 = beat_cnt;
        send_tile(0, 1, 0);
        wait_beats(b0 + 40);
        stall(1);
        wait_beats(b0 + 60);
        stall(5);
        wait_beats(b0 + 94);
        stall(5);
        drain();

        // Idle gap, then a slowly written tile
        send_tile(0, 1, 0);
        repeat (300) begin @(posedge clk); #1; end
        chk("idle_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_valid_low", 64'(Feature_Input_Valid), 64'd0);
        arm_first = 1'b1;
        send_tile(2, 1, 0);
        check_latency();
        drain();

        // Reset in the middle of a replay
        b0 = beat_cnt;
        send_tile(0, 1, 0);
        wait_beats(b0 + 100);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(Feature_Input_Valid), 64'd0);
        chk("midreset_feature_input", Feature_Input[63:0], 64'd0);
        chk("midreset_flags", 64'({weight_grp, group_first, group_last, tile_done}), 64'd0);
        chk("midreset_s_ready", 64'(s_ready), 64'd1);
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        @(posedge clk); #1;
        arm_first = 1'b1;
        send_tile(0, 0, 0);
        check_latency();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
